io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter SW_WIDTH, default 10: width of the switch input bus.
REQ-002 Parameter DATA_WIDTH, default 32: width of the CPU data path.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 io_req  in  1  one-cycle request strobe from the CPU.
REQ-006 io_op  in  2  01 = read input, 10 = write display, 00/11 = no operation.
REQ-007 wr_data  in  DATA_WIDTH  value to display; sampled on an accepted write.
REQ-008 button  in  1  raw asynchronous board push-button.
REQ-009 switches  in  SW_WIDTH  raw board switches.
REQ-010 rd_data  out  DATA_WIDTH  captured input value, zero-extended.
REQ-011 rd_valid  out  1  one-cycle pulse when rd_data is updated.
REQ-012 stall  out  1  high while state is not IDLE; the CPU holds its PC.
REQ-013 overflow  out  1  last write exceeded 999; sticky until the next accepted write.
REQ-014 unidade, dezena, centena  out  4 each  BCD ones, tens and hundreds digits.

Function
REQ-015 Four states: IDLE, WAIT_BTN, CONVERT, LOAD.
REQ-016 A request is accepted on an edge with io_req=1, state=IDLE and io_op in {01, 10}.
REQ-017 A request with io_req=1 is ignored, with no state change, when state is not IDLE or when io_op is 00 or 11.
REQ-018 button and switches each pass through a 2-flop synchronizer; the press event is a rising edge of synchronized button.
REQ-019 Accepted read: IDLE->WAIT_BTN; a press event that coincides with acceptance, or any press before it, is ignored.
REQ-020 In WAIT_BTN, on the edge where the press event is high: rd_data <= zero-extended synchronized switches, rd_valid=1 for exactly one cycle, state->IDLE.
REQ-021 A button held high from before the read request does not complete the read; a new rising edge is required.
REQ-022 Accepted write when wr_data <= 999: latch wr_data[9:0], clear overflow, state->CONVERT.
REQ-023 In CONVERT: sequential double-dabble, one bit per cycle, MSB first, exactly 10 cycles; then LOAD.
REQ-024 In LOAD: unidade/dezena/centena update together on the same edge, then state->IDLE.
REQ-025 Digit outputs never show partial conversion results.
REQ-026 Write latency: acceptance edge E0, digits change on edge E11, stall high in cycles E0..E11.
REQ-027 Accepted write when wr_data > 999 (any upper bit set): overflow<=1, digits<=9,9,9 on the acceptance edge, state remains IDLE, no stall.
REQ-028 rd_data holds its value between reads; digits hold between writes.
REQ-029 stall is registered-state derived, with no combinational path from io_req.

Reset
REQ-030 On reset assertion, immediately and including mid-operation: state=IDLE, rd_data=0, rd_valid=0, stall=0, overflow=0, all digits 0, synchronizers and converter cleared.
REQ-031 An operation interrupted by reset is discarded and is not resumed.

Structure
REQ-032 Shared package io_pkg holds the state enum, the op codes (OP_NONE, OP_READ, OP_WRITE) and MAX_DISPLAY=999.
REQ-033 A single sub-module bin2bcd_seq implements the iterative converter with start/done handshake; the FSM, synchronizers and output registers stay in io_responder.

Verification
REQ-034 After reset, write 347 -> digits 3,4,7 on edge E11; stall high E0..E11; overflow 0.
REQ-035 Write 1000 -> overflow=1, digits 9,9,9 on the acceptance edge, stall never high; then write 5 -> overflow=0, digits 0,0,5.
REQ-036 Read with switches=10'h2A5 and button pressed 20 cycles later -> stall high until the press; rd_data=32'h000002A5; rd_valid high exactly one cycle.
REQ-037 Button held high before and during a read request -> no completion; release then press again -> completes.
REQ-038 Assert reset at the 5th CONVERT cycle of a write of 999 -> all outputs 0 immediately; digits stay 0,0,0 after reset is released.
REQ-039 io_req during CONVERT, and io_op=11 in IDLE -> both ignored; the first write still completes with correct digits.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O responder: FSM states, op codes and
// converter sizing.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BTN = 2'd1,
    CONVERT  = 2'd2,
    LOAD     = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  // Largest value the three-digit display can show.
  localparam int MAX_DISPLAY = 999;

  // Converter sizing: 10 binary bits in, three BCD digits out.
  localparam int BIN_W = 10;
  localparam int BCD_W = 12;
  localparam int CNT_W = 4;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one input bit per
// cycle, MSB first. A start pulse loads the operand; done is high during
// the cycle whose closing edge performs the final shift, so bcd holds the
// complete result from the following cycle until the next start.
module bin2bcd_seq
  import io_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_W / 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? (v[4*i +: 4] + 4'd3) : v[4*i +: 4];
    end
    return r;
  endfunction

  // Next-state: load on start, otherwise shift one bit per cycle while busy.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CNT_W'(BIN_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Operands never exceed 999, so the bit shifted out of the top is 0.
      bcd_d = BCD_W'({dabble_adjust(bcd_q), bin_q[BIN_W-1]});
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter registers, cleared by reset so an interrupted conversion is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/io_responder.sv
// CPU-facing I/O responder: a read waits for a fresh push-button press and
// returns the synchronized switches; a write converts the value to three
// BCD display digits (or shows 999 with overflow when it does not fit).
// The CPU stalls while any operation is in progress.
module io_responder
  import io_pkg::*;
#(
  parameter int SW_WIDTH   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req,
  input  logic [1:0]            io_op,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  button,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  stall,
  output logic                  overflow,
  output logic [3:0]            unidade,
  output logic [3:0]            dezena,
  output logic [3:0]            centena
);

  state_t                state_q, state_d;
  logic                  btn_meta_q, btn_meta_d;
  logic                  btn_sync_q, btn_sync_d;
  logic                  btn_prev_q, btn_prev_d;
  logic [SW_WIDTH-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]   sw_sync_q, sw_sync_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  stall_q, stall_d;
  logic                  overflow_q, overflow_d;
  logic [3:0]            unidade_q, unidade_d;
  logic [3:0]            dezena_q, dezena_d;
  logic [3:0]            centena_q, centena_d;

  logic                  press;
  logic                  accept;
  logic                  wr_big;
  logic                  conv_start;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;

  assign press      = btn_sync_q & ~btn_prev_q;
  assign accept     = io_req && (state_q == IDLE) && ((io_op == OP_READ) || (io_op == OP_WRITE));
  assign wr_big     = wr_data > DATA_WIDTH'(MAX_DISPLAY);
  assign conv_start = accept && (io_op == OP_WRITE) && !wr_big;

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (wr_data[BIN_W-1:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Next-state and output register values for the FSM and synchronizers.
  always_comb begin
    state_d    = state_q;
    btn_meta_d = button;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    sw_meta_d  = switches;
    sw_sync_d  = sw_meta_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    unidade_d  = unidade_q;
    dezena_d   = dezena_q;
    centena_d  = centena_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (io_op == OP_READ) begin
            // Any press up to and including this edge is deliberately ignored.
            state_d = WAIT_BTN;
          end else if (wr_big) begin
            overflow_d = 1'b1;
            unidade_d  = 4'd9;
            dezena_d   = 4'd9;
            centena_d  = 4'd9;
          end else begin
            overflow_d = 1'b0;
            state_d    = CONVERT;
          end
        end
      end
      WAIT_BTN: begin
        if (press) begin
          rd_data_d  = DATA_WIDTH'(sw_sync_q);
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        unidade_d = conv_bcd[3:0];
        dezena_d  = conv_bcd[7:4];
        centena_d = conv_bcd[11:8];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d != IDLE);
  end

  // All FSM state, synchronizers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      unidade_q  <= 4'd0;
      dezena_q   <= 4'd0;
      centena_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      unidade_q  <= unidade_d;
      dezena_q   <= dezena_d;
      centena_q  <= centena_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign stall    = stall_q;
  assign overflow = overflow_q;
  assign unidade  = unidade_q;
  assign dezena   = dezena_q;
  assign centena  = centena_q;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: behavioural model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_io_responder;

  localparam int SW_W = 10;
  localparam int DW   = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            io_req = 1'b0;
  logic [1:0]      io_op = 2'b00;
  logic [DW-1:0]   wr_data = '0;
  logic            button = 1'b0;
  logic [SW_W-1:0] switches = '0;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            stall;
  logic            overflow;
  logic [3:0]      unidade, dezena, centena;

  io_responder #(.SW_WIDTH(SW_W), .DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_req   (io_req),
    .io_op    (io_op),
    .wr_data  (wr_data),
    .button   (button),
    .switches (switches),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .stall    (stall),
    .overflow (overflow),
    .unidade  (unidade),
    .dezena   (dezena),
    .centena  (centena)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs as seen at the last three edges (index 0 = most recent).
  logic            hb [3] = '{1'b0, 1'b0, 1'b0};
  logic [SW_W-1:0] hs [3] = '{'0, '0, '0};
  bit              m_wait_rd = 0;
  int              m_wr_left = 0;
  logic [31:0]     m_rd_data = '0;
  logic            m_rd_valid = 1'b0;
  logic            m_ovf = 1'b0;
  logic [3:0]      m_h = 0, m_t = 0, m_u = 0;
  logic [3:0]      p_h = 0, p_t = 0, p_u = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hb[i] = 1'b0;
      hs[i] = '0;
    end
    m_wait_rd = 0; m_wr_left = 0; m_rd_data = '0; m_rd_valid = 1'b0;
    m_ovf = 1'b0; m_h = 0; m_t = 0; m_u = 0;
  endtask

  task automatic model_step();
    logic            press;
    logic [SW_W-1:0] swc;
    int              v;
    // A button level seen two edges ago that was low three edges ago is a press.
    press = hb[1] && !hb[2];
    swc   = hs[1];
    hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = button;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = switches;
    m_rd_valid = 1'b0;
    if (m_wait_rd) begin
      if (press) begin
        m_rd_data  = 32'(swc);
        m_rd_valid = 1'b1;
        m_wait_rd  = 0;
      end
    end else if (m_wr_left > 0) begin
      m_wr_left--;
      if (m_wr_left == 0) begin
        m_h = p_h; m_t = p_t; m_u = p_u;
      end
    end else if (io_req && (io_op == 2'b01)) begin
      m_wait_rd = 1;
    end else if (io_req && (io_op == 2'b10)) begin
      if (wr_data > 999) begin
        m_ovf = 1'b1; m_h = 9; m_t = 9; m_u = 9;
      end else begin
        v = int'(wr_data);
        m_ovf = 1'b0;
        p_h = 4'(v / 100); p_t = 4'((v / 10) % 10); p_u = 4'(v % 10);
        m_wr_left = 11;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("rd_data",  rd_data, m_rd_data);
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("stall",    32'(stall), 32'(m_wait_rd || (m_wr_left > 0)));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("digits",   {20'd0, centena, dezena, unidade}, {20'd0, m_h, m_t, m_u});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] data);
    io_req = 1'b1; io_op = op; wr_data = data;
    tick(1);
    io_req = 1'b0; io_op = 2'b00;
  endtask

  function automatic logic [31:0] digs();
    return {20'd0, centena, dezena, unidade};
  endfunction

  initial begin
    tick(3);
    reset = 1'b0;
    check("reset_digits", digs(), 32'h000);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    tick(2);

    // Write 347: digits change on E11, stall high until then.
    request(2'b10, 32'd347);
    check("w347_stall_e0", 32'(stall), 32'h1);
    tick(10);
    check("w347_digits_e10", digs(), 32'h000);
    check("w347_stall_e10", 32'(stall), 32'h1);
    tick(1);
    check("w347_digits_e11", digs(), 32'h347);
    check("w347_stall_e11", 32'(stall), 32'h0);
    check("w347_ovf", 32'(overflow), 32'h0);
    tick(2);

    // Write 1000: overflow with 999 immediately, no stall; then write 5.
    request(2'b10, 32'd1000);
    check("w1000_ovf", 32'(overflow), 32'h1);
    check("w1000_digits", digs(), 32'h999);
    check("w1000_stall", 32'(stall), 32'h0);
    tick(2);
    request(2'b10, 32'd5);
    check("w5_ovf_clear", 32'(overflow), 32'h0);
    tick(11);
    check("w5_digits", digs(), 32'h005);
    tick(2);

    // Read with switches 2A5, press 20 cycles later.
    switches = 10'h2A5;
    tick(3);
    request(2'b01, 32'd0);
    tick(20);
    check("rd_wait_stall", 32'(stall), 32'h1);
    check("rd_wait_valid", 32'(rd_valid), 32'h0);
    button = 1'b1;
    tick(3);
    check("rd_valid_pulse", 32'(rd_valid), 32'h1);
    check("rd_data_2a5", rd_data, 32'h000002A5);
    check("rd_stall_done", 32'(stall), 32'h0);
    tick(1);
    check("rd_valid_one_cycle", 32'(rd_valid), 32'h0);
    button = 1'b0;
    switches = 10'h0F0;
    tick(4);
    check("rd_data_hold", rd_data, 32'h000002A5);

    // Button already held when the read arrives: needs a fresh press.
    button = 1'b1;
    tick(4);
    request(2'b01, 32'd0);
    tick(10);
    check("held_no_complete", 32'(stall), 32'h1);
    button = 1'b0;
    tick(4);
    check("held_release_stall", 32'(stall), 32'h1);
    switches = 10'h155;
    button = 1'b1;
    tick(3);
    check("held_repress_valid", 32'(rd_valid), 32'h1);
    check("held_repress_data", rd_data, 32'h00000155);
    button = 1'b0;
    tick(3);

    // Reset during the 5th CONVERT cycle of a write of 999.
    request(2'b10, 32'd999);
    tick(4);
    reset = 1'b1;
    #1;
    check("rst_mid_digits", digs(), 32'h000);
    check("rst_mid_stall", 32'(stall), 32'h0);
    check("rst_mid_rd_data", rd_data, 32'h0);
    check("rst_mid_ovf", 32'(overflow), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(15);
    check("rst_no_resume_digits", digs(), 32'h000);
    check("rst_no_resume_stall", 32'(stall), 32'h0);

    // Requests during CONVERT and io_op=11 / 00 in IDLE are ignored.
    request(2'b10, 32'd250);
    tick(3);
    request(2'b10, 32'd777);
    tick(6);
    check("ign_stall_e10", 32'(stall), 32'h1);
    tick(1);
    check("ign_digits_250", digs(), 32'h250);
    request(2'b11, 32'd123);
    check("op11_stall", 32'(stall), 32'h0);
    request(2'b00, 32'd456);
    tick(13);
    check("op11_digits", digs(), 32'h250);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
